dma_reg_bank: RTL and testbench

Parametrised multi-channel DMA register bank. It replaces the single-channel register interface with NUM_CH independent channel register sets. Each channel tracks its own transfer: a START pulse, a remaining-beat countdown, and DONE/ERR status. The bank has a read-valid handshake and an interrupt output, and sits between the CPU-side register bus and the DMA transfer engine.

---
 rtl/dma_reg_pkg.sv | 36 +++
 rtl/dma_reg_bank_if.sv | 23 ++
 rtl/dma_reg_channel.sv | 89 ++++++++
 rtl/dma_reg_bank.sv | 126 ++++++++++++
 tb/tb_dma_reg_bank.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_reg_pkg.sv
// dma_reg_pkg: register map, CTRL/STATUS bit positions and per-channel state.
// Stored widths are the widest supported; narrower parameters zero-extend.
package dma_reg_pkg;

    localparam int DMA_DW = 32;
    localparam int DMA_LW = 16;

    localparam logic [2:0] REG_SRC    = 3'd0;
    localparam logic [2:0] REG_DST    = 3'd1;
    localparam logic [2:0] REG_LEN    = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_REMAIN = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_ERR    = 2;

    typedef struct packed {
        logic [DMA_DW-1:0] src;
        logic [DMA_DW-1:0] dst;
        logic [DMA_LW-1:0] len;
        logic              irq_en;
        logic              busy;
        logic              done;
        logic              err;
        logic [DMA_LW-1:0] remain;
    } ch_regs_t;

    function automatic logic reg_legal(input logic [2:0] off);
        return off <= REG_REMAIN;
    endfunction

endpackage

// File: rtl/dma_reg_bank_if.sv
// dma_reg_bank_if: CPU-side register bus with registered read return and err.
interface dma_reg_bank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  err;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, rdata_valid, err
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, rdata_valid, err
    );
endinterface

// File: rtl/dma_reg_channel.sv
// dma_reg_channel: one channel's registers, START/beat/W1C handling, start pulse.
// reject flags a write refused because the channel is busy.
module dma_reg_channel
    import dma_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [2:0]            reg_off,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  beat,
    output ch_regs_t              regs,
    output logic                  ch_start,
    output logic                  reject
);

    ch_regs_t          regs_q, regs_d;
    logic              ch_start_q, ch_start_d;
    logic [DMA_LW-1:0] wlen;

    assign wlen = DMA_LW'(wdata[LEN_WIDTH-1:0]);

    always_comb begin
        regs_d     = regs_q;
        ch_start_d = 1'b0;
        reject     = 1'b0;
        if (wr) begin
            unique case (reg_off)
                REG_SRC: begin
                    if (regs_q.busy) reject = 1'b1;
                    else regs_d.src = DMA_DW'(wdata);
                end
                REG_DST: begin
                    if (regs_q.busy) reject = 1'b1;
                    else regs_d.dst = DMA_DW'(wdata);
                end
                REG_LEN: begin
                    if (regs_q.busy) reject = 1'b1;
                    else regs_d.len = wlen;
                end
                REG_CTRL: begin
                    regs_d.irq_en = wdata[CTRL_IRQ_EN];
                    if (wdata[CTRL_START]) begin
                        if (regs_q.busy) begin
                            reject = 1'b1;
                        end else if (regs_q.len == '0) begin
                            regs_d.done = 1'b1;
                        end else begin
                            regs_d.busy   = 1'b1;
                            regs_d.remain = regs_q.len;
                            ch_start_d    = 1'b1;
                        end
                    end
                end
                REG_STATUS: begin
                    if (wdata[STAT_DONE]) regs_d.done = 1'b0;
                    if (wdata[STAT_ERR])  regs_d.err  = 1'b0;
                end
                default: ;
            endcase
        end
        if (reject) regs_d.err = 1'b1;
        // applied after W1C so a completing beat wins over a DONE clear
        if (beat && regs_q.busy) begin
            regs_d.remain = regs_q.remain - DMA_LW'(1);
            if (regs_q.remain == DMA_LW'(1)) begin
                regs_d.busy = 1'b0;
                regs_d.done = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q     <= '0;
            ch_start_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            ch_start_q <= ch_start_d;
        end
    end

    assign regs     = regs_q;
    assign ch_start = ch_start_q;

endmodule

// File: rtl/dma_reg_bank.sv
// dma_reg_bank: NUM_CH DMA channel register sets behind one register bus.
// Holds address decode, illegal-access check, registered read mux and irq.
module dma_reg_bank
    import dma_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    dma_reg_bank_if.slave                bus,
    output logic [NUM_CH-1:0]            ch_start,
    output logic [NUM_CH-1:0]            ch_busy,
    output logic [NUM_CH*DATA_WIDTH-1:0] ch_src,
    output logic [NUM_CH*DATA_WIDTH-1:0] ch_dst,
    input  logic [NUM_CH-1:0]            beat,
    output logic                         irq
);

    localparam int CH_W = ADDR_WIDTH - 3;

    logic [CH_W-1:0]       ch_idx;
    logic [2:0]            reg_off;
    ch_regs_t              regs [NUM_CH];
    ch_regs_t              sel;
    logic [NUM_CH-1:0]     wr_ch;
    logic [NUM_CH-1:0]     reject;
    logic [NUM_CH-1:0]     done_irq;
    logic                  ch_ok;
    logic                  addr_ok;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  collide;
    logic [DATA_WIDTH-1:0] rval;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  err_q, err_d;

    assign ch_idx  = bus.addr[ADDR_WIDTH-1:3];
    assign reg_off = bus.addr[2:0];

    always_comb begin
        ch_ok = 1'b0;
        sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == CH_W'(i)) begin
                ch_ok = 1'b1;
                sel   = regs[i];
            end
        end
    end

    always_comb begin
        rval = '0;
        unique case (reg_off)
            REG_SRC:    rval = DATA_WIDTH'(sel.src);
            REG_DST:    rval = DATA_WIDTH'(sel.dst);
            REG_LEN:    rval = DATA_WIDTH'(sel.len);
            REG_CTRL:   rval[CTRL_IRQ_EN] = sel.irq_en;
            REG_STATUS: begin
                rval[STAT_BUSY] = sel.busy;
                rval[STAT_DONE] = sel.done;
                rval[STAT_ERR]  = sel.err;
            end
            REG_REMAIN: rval = DATA_WIDTH'(sel.remain);
            default:    rval = '0;
        endcase
    end

    // a collided strobe pair keeps the write and drops the read
    always_comb begin
        collide       = bus.wr_en && bus.rd_en;
        addr_ok       = ch_ok && reg_legal(reg_off);
        wr_ok         = bus.wr_en && addr_ok;
        rd_ok         = bus.rd_en && !bus.wr_en;
        err_d         = ((bus.wr_en || bus.rd_en) && !addr_ok)
                        || collide || (|reject);
        rdata_valid_d = rd_ok;
        rdata_d       = (rd_ok && addr_ok) ? rval : '0;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_ch[g] = wr_ok && (ch_idx == CH_W'(g));

        dma_reg_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .LEN_WIDTH  (LEN_WIDTH)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr       (wr_ch[g]),
            .reg_off  (reg_off),
            .wdata    (bus.wdata),
            .beat     (beat[g]),
            .regs     (regs[g]),
            .ch_start (ch_start[g]),
            .reject   (reject[g])
        );

        assign ch_busy[g] = regs[g].busy;
        assign ch_src[g*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(regs[g].src);
        assign ch_dst[g*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(regs[g].dst);
        assign done_irq[g] = regs[g].done & regs[g].irq_en;
    end

    assign irq = |done_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            err_q         <= err_d;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_dma_reg_bank.sv
// tb_dma_reg_bank: directed and random stimulus against a per-channel array model.
module tb_dma_reg_bank;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int NCH = 4;
    localparam int LW  = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NCH-1:0]     beat = '0;
    logic [NCH-1:0]     ch_start;
    logic [NCH-1:0]     ch_busy;
    logic [NCH*DW-1:0]  ch_src;
    logic [NCH*DW-1:0]  ch_dst;
    logic               irq;

    dma_reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dma_reg_bank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_CH     (NCH),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ch_start (ch_start),
        .ch_busy  (ch_busy),
        .ch_src   (ch_src),
        .ch_dst   (ch_dst),
        .beat     (beat),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    bit [31:0]      m_src [NCH];
    bit [31:0]      m_dst [NCH];
    bit [15:0]      m_len [NCH];
    bit [15:0]      m_rem [NCH];
    bit             m_ie  [NCH];
    bit             m_busy[NCH];
    bit             m_done[NCH];
    bit             m_err [NCH];
    bit [31:0]      e_rdata;
    bit             e_rv;
    bit             e_err;
    bit [NCH-1:0]   e_start;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] m_read(input int c, input int o);
        case (o)
            0:       return m_src[c];
            1:       return m_dst[c];
            2:       return 32'(m_len[c]);
            3:       return {30'd0, m_ie[c], 1'b0};
            4:       return {29'd0, m_err[c], m_done[c], m_busy[c]};
            5:       return 32'(m_rem[c]);
            default: return 32'd0;
        endcase
    endfunction

    int m_c, m_o;
    bit m_legal, m_w, m_r;
    bit [31:0] m_wd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_src[i] = 0; m_dst[i] = 0; m_len[i] = 0; m_rem[i] = 0;
                m_ie[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0;
            end
            e_rdata = 0; e_rv = 0; e_err = 0; e_start = 0;
        end else begin
            m_c     = int'(bus.addr[7:3]);
            m_o     = int'(bus.addr[2:0]);
            m_w     = bus.wr_en;
            m_r     = bus.rd_en;
            m_wd    = bus.wdata;
            m_legal = (m_c < NCH) && (m_o < 6);
            e_start = 0;
            e_rv    = m_r && !m_w;
            e_rdata = (e_rv && m_legal) ? m_read(m_c, m_o) : 32'd0;
            e_err   = ((m_w || m_r) && !m_legal) || (m_w && m_r);
            if (m_w && m_legal) begin
                if (m_o < 3 && m_busy[m_c]) begin
                    e_err = 1; m_err[m_c] = 1;
                end else if (m_o == 0) m_src[m_c] = m_wd;
                else if (m_o == 1) m_dst[m_c] = m_wd;
                else if (m_o == 2) m_len[m_c] = m_wd[15:0];
                else if (m_o == 3) begin
                    m_ie[m_c] = m_wd[1];
                    if (m_wd[0]) begin
                        if (m_busy[m_c]) begin
                            e_err = 1; m_err[m_c] = 1;
                        end else if (m_len[m_c] == 0) m_done[m_c] = 1;
                        else begin
                            m_busy[m_c] = 1;
                            m_rem[m_c]  = m_len[m_c];
                            e_start[m_c] = 1;
                        end
                    end
                end else if (m_o == 4) begin
                    if (m_wd[1]) m_done[m_c] = 0;
                    if (m_wd[2]) m_err[m_c]  = 0;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (beat[i] && m_busy[i] && !e_start[i]) begin
                    m_rem[i] = m_rem[i] - 1;
                    if (m_rem[i] == 0) begin
                        m_busy[i] = 0; m_done[i] = 1;
                    end
                end
            end
        end
    end

    function automatic bit [NCH-1:0] m_busy_vec();
        bit [NCH-1:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit m_irq();
        bit v = 0;
        for (int i = 0; i < NCH; i++) v |= m_done[i] & m_ie[i];
        return v;
    endfunction

    function automatic bit [NCH*DW-1:0] m_addr_vec(input bit dst);
        bit [NCH*DW-1:0] v = '0;
        for (int i = 0; i < NCH; i++)
            v[i*DW +: DW] = dst ? m_dst[i] : m_src[i];
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata_valid", bus.rdata_valid, e_rv);
            chk("err", bus.err, e_err);
            if (e_rv) chk("rdata", bus.rdata, e_rdata);
            chk("ch_start", ch_start, e_start);
            chk("ch_busy", ch_busy, m_busy_vec());
            chk("irq", irq, m_irq());
            chk("ch_src", ch_src, m_addr_vec(0));
            chk("ch_dst", ch_dst, m_addr_vec(1));
        end
    end

    task automatic drive(input bit w, input bit r, input int c, input int o,
                         input logic [31:0] d, input logic [NCH-1:0] b);
        bus.wr_en = w;
        bus.rd_en = r;
        bus.addr  = {c[4:0], o[2:0]};
        bus.wdata = d;
        beat      = b;
        @(posedge clk);
        #2;
        bus.wr_en = 0;
        bus.rd_en = 0;
        beat      = '0;
    endtask

    int c, o;
    bit w, r;
    logic [31:0] d;

    initial begin
        bus.wr_en = 0; bus.rd_en = 0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_rvalid", bus.rdata_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_start", ch_start, 0);
        chk("rst_busy", ch_busy, 0);
        chk("rst_irq", irq, 0);
        rst = 0;
        chk_en = 1;

        for (int ci = 0; ci < NCH; ci++)
            for (int oi = 0; oi < 6; oi++) begin
                drive(0, 1, ci, oi, 0, 0);
                chk("init_rdata", bus.rdata, 0);
                chk("init_rvalid", bus.rdata_valid, 1);
            end
        chk("init_irq", irq, 0);

        drive(1, 0, 1, 0, 32'h1000, 0);
        drive(1, 0, 1, 2, 3, 0);
        drive(1, 0, 1, 3, 3, 0);
        chk("c1_start", ch_start, 4'b0010);
        chk("c1_busy", ch_busy[1], 1);
        chk("c1_model_rem", m_rem[1], 3);
        chk("c1_src", ch_src[63:32], 32'h1000);
        drive(0, 1, 1, 5, 0, 0);
        chk("c1_start_gone", ch_start, 0);
        chk("c1_remain3", bus.rdata, 3);
        drive(0, 1, 1, 3, 0, 0);
        chk("c1_ctrl", bus.rdata, 2);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 4'b0010);
            drive(0, 1, 1, 5, 0, 0);
            chk("c1_remain", bus.rdata, 2 - k);
        end
        chk("c1_idle", ch_busy[1], 0);
        chk("c1_irq", irq, 1);
        drive(0, 1, 1, 4, 0, 0);
        chk("c1_status", bus.rdata, 2);
        drive(1, 0, 1, 4, 2, 0);
        chk("c1_irq_clr", irq, 0);

        drive(1, 0, 0, 3, 1, 0);
        chk("c0_nostart", ch_start, 0);
        chk("c0_nobusy", ch_busy[0], 0);
        drive(0, 1, 0, 4, 0, 0);
        chk("c0_done", bus.rdata, 2);
        drive(1, 0, 0, 4, 2, 0);

        drive(1, 0, 2, 2, 4, 0);
        drive(1, 0, 2, 3, 1, 0);
        chk("c2_busy", ch_busy[2], 1);
        drive(1, 0, 2, 2, 5, 0);
        chk("c2_len_err", bus.err, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("c2_err_low", bus.err, 0);
        drive(1, 0, 2, 3, 1, 0);
        chk("c2_restart_err", bus.err, 1);
        chk("c2_no_start", ch_start, 0);
        drive(0, 1, 2, 4, 0, 0);
        chk("c2_status", bus.rdata, 5);
        drive(0, 1, 2, 5, 0, 0);
        chk("c2_remain", bus.rdata, 4);
        drive(0, 1, 2, 2, 0, 0);
        chk("c2_len", bus.rdata, 4);

        drive(1, 0, 5, 0, 32'hdead, 0);
        chk("bad_ch_wr_err", bus.err, 1);
        drive(0, 1, 5, 0, 0, 0);
        chk("bad_ch_rdata", bus.rdata, 0);
        chk("bad_ch_rvalid", bus.rdata_valid, 1);
        chk("bad_ch_rd_err", bus.err, 1);
        drive(0, 1, 0, 7, 0, 0);
        chk("bad_off_rdata", bus.rdata, 0);
        chk("bad_off_rvalid", bus.rdata_valid, 1);
        chk("bad_off_err", bus.err, 1);
        drive(1, 1, 3, 0, 32'hABCD, 0);
        chk("both_err", bus.err, 1);
        chk("both_rvalid", bus.rdata_valid, 0);
        drive(0, 1, 3, 0, 0, 0);
        chk("both_landed", bus.rdata, 32'hABCD);
        chk("both_err_low", bus.err, 0);

        drive(0, 0, 0, 0, 0, 4'b0100);
        drive(0, 0, 0, 0, 0, 4'b0100);
        chk("c2_model_rem2", m_rem[2], 2);
        #1 rst = 1;
        #1;
        chk("arst_busy", ch_busy, 0);
        chk("arst_src", ch_src, 0);
        chk("arst_start", ch_start, 0);
        chk("arst_err", bus.err, 0);
        chk("arst_rvalid", bus.rdata_valid, 0);
        chk("arst_irq", irq, 0);
        @(posedge clk);
        #2 rst = 0;
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 4'b0100);
        chk("post_rst_busy", ch_busy, 0);
        chk("post_rst_start", ch_start, 0);
        drive(0, 1, 2, 5, 0, 0);
        chk("post_rst_remain", bus.rdata, 0);
        drive(0, 1, 2, 4, 0, 0);
        chk("post_rst_status", bus.rdata, 0);

        for (int n = 0; n < 1500; n++) begin
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 7))
                                            : int'($urandom_range(0, 3));
            o = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7))
                                            : int'($urandom_range(0, 5));
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            d = $urandom;
            if (o == 2) d = $urandom_range(0, 6);
            if (o == 3) d = $urandom_range(0, 3);
            if (o == 4) d = $urandom_range(0, 7);
            drive(w, r, c, o, d, NCH'($urandom_range(0, 15)));
            if (n == 700) begin
                #1 rst = 1;
                #1 rst = 0;
            end
        end

        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
